// File: rtl/wave_seq_ctrl.sv
// Phase-accumulator sequencer for a quarter-wave sine memory.
// Produces read address, quadrant negate flag and wrap pulse.
module wave_seq_ctrl #(
    parameter int ADDR_WIDTH  = 7,
    parameter int PHASE_WIDTH = 16,
    parameter int DIV_WIDTH   = 8,
    parameter int INC_RESET   = 512
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [PHASE_WIDTH-1:0] cfg_phase_inc,
    input  logic [DIV_WIDTH-1:0]   cfg_div,
    input  logic                   start,
    input  logic                   stop,
    output logic [ADDR_WIDTH-1:0]  rom_addr,
    output logic                   sample_valid,
    output logic                   negate,
    output logic                   wrap,
    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOPPING
    } state_t;

    state_t state;
    state_t state_nx;

    logic [PHASE_WIDTH-1:0] phase;
    logic [PHASE_WIDTH-1:0] inc;
    logic [PHASE_WIDTH-1:0] pend_inc;
    logic [DIV_WIDTH-1:0]   div;
    logic [DIV_WIDTH-1:0]   div_cnt;
    logic [DIV_WIDTH-1:0]   pend_div;
    logic                   pending;
    logic                   neg_d;
    logic                   tick_q;

    logic                   tick;
    logic                   carry;
    logic                   cfg_acc;
    logic [PHASE_WIDTH:0]   sum;
    logic [1:0]             quad;
    logic [ADDR_WIDTH-1:0]  idx;
    logic [ADDR_WIDTH-1:0]  addr_nx;

    assign busy      = (state != IDLE);
    assign cfg_ready = (state != STOPPING) && !pending;
    assign cfg_acc   = cfg_valid && cfg_ready;
    assign tick      = (state != IDLE) && (div_cnt == div);

    assign sum   = {1'b0, phase} + {1'b0, inc};
    assign carry = sum[PHASE_WIDTH];
    assign quad  = phase[PHASE_WIDTH-1 -: 2];
    assign idx   = phase[PHASE_WIDTH-3 -: ADDR_WIDTH];
    // odd quadrants read the table backwards; ~idx == (2^N-1) - idx
    assign addr_nx = quad[0] ? ~idx : idx;

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // next-state: stop only completes on an overflowing tick
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:     if (start)          state_nx = RUN;
            RUN:      if (stop)           state_nx = STOPPING;
            STOPPING: if (tick && carry)  state_nx = IDLE;
            default:                      state_nx = IDLE;
        endcase
    end

    // phase accumulator, divider, config shadow and output pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            phase        <= '0;
            inc          <= PHASE_WIDTH'(INC_RESET);
            div          <= '0;
            div_cnt      <= '0;
            pending      <= 1'b0;
            pend_inc     <= '0;
            pend_div     <= '0;
            rom_addr     <= '0;
            neg_d        <= 1'b0;
            tick_q       <= 1'b0;
            sample_valid <= 1'b0;
            negate       <= 1'b0;
            wrap         <= 1'b0;
        end else begin
            wrap         <= 1'b0;
            tick_q       <= tick;
            sample_valid <= tick_q;
            negate       <= neg_d;
            if (state == IDLE) begin
                div_cnt <= '0;
                if (cfg_acc) begin
                    inc <= cfg_phase_inc;
                    div <= cfg_div;
                end
                if (start) begin
                    phase <= '0;
                end
            end else begin
                div_cnt <= tick ? '0 : div_cnt + 1'b1;
                if (cfg_acc) begin
                    pending  <= 1'b1;
                    pend_inc <= cfg_phase_inc;
                    pend_div <= cfg_div;
                end
                if (tick) begin
                    rom_addr <= addr_nx;
                    neg_d    <= quad[1];
                    phase    <= sum[PHASE_WIDTH-1:0];
                    wrap     <= carry;
                    // new settings only at period boundaries
                    if (carry && pending) begin
                        inc     <= pend_inc;
                        div     <= pend_div;
                        pending <= 1'b0;
                    end
                    if (carry && (state == STOPPING)) begin
                        phase <= '0;
                    end
                end
            end
        end
    end

endmodule
